// File: rtl/dac_pkg.sv
// Shared types, widths and the clamped adder for the stereo sigma-delta DAC datapath.
package dac_pkg;

  localparam int unsigned DAC_DATA_WIDTH = 16;
  localparam int unsigned DAC_ACC_WIDTH  = 20;
  localparam int unsigned DAC_CNT_WIDTH  = 16;
  localparam int unsigned DAC_FS         = 1 << (DAC_DATA_WIDTH - 1);

  // Working width for integrator arithmetic; wide enough that no sum can wrap.
  localparam int unsigned DAC_SUM_W = 32;

  typedef logic signed [DAC_SUM_W-1:0] dac_sum_t;

  typedef enum logic {
    DAC_CH_L = 1'b0,
    DAC_CH_R = 1'b1
  } dac_ch_e;

  typedef struct packed {
    logic                 sat;
    logic [DAC_SUM_W-1:0] val;
  } dac_sat_t;

  // Clamp a + b to +/-(2^(acc_w-1)-1); sat reports whether clamping occurred.
  function automatic dac_sat_t sat_add(input dac_sum_t a, input dac_sum_t b,
                                       input int unsigned acc_w);
    dac_sat_t res;
    dac_sum_t s;
    dac_sum_t lim;
    s   = a + b;
    lim = (dac_sum_t'(1) <<< (acc_w - 1)) - dac_sum_t'(1);
    res.sat = 1'b1;
    if (s > lim) begin
      res.val = lim;
    end else if (s < -lim) begin
      res.val = -lim;
    end else begin
      res.val = s;
      res.sat = 1'b0;
    end
    return res;
  endfunction

endpackage

// File: rtl/dac_sd_channel.sv
// One 2nd-order sigma-delta modulator: two clamped integrators and a registered PDM bit.
module dac_sd_channel
  import dac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DAC_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DAC_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [ACC_WIDTH-1:0] x,
  input  logic                 step,
  input  logic                 clear,
  output logic                 pdm,
  output logic                 sat
);

  localparam dac_sum_t FB_MAG = dac_sum_t'(1) <<< (DATA_WIDTH - 1);

  logic signed [ACC_WIDTH-1:0] r_i1;
  logic signed [ACC_WIDTH-1:0] r_i2;
  logic                        r_pdm;

  dac_sum_t w_x;
  dac_sum_t w_fb;
  dac_sat_t w_i1n;
  dac_sat_t w_i2n;

  // Second integrator consumes the already-updated first integrator (no delay).
  always_comb begin
    w_x   = dac_sum_t'($signed(x));
    w_fb  = r_pdm ? FB_MAG : -FB_MAG;
    w_i1n = sat_add(dac_sum_t'(r_i1), w_x - w_fb, ACC_WIDTH);
    w_i2n = sat_add(dac_sum_t'(r_i2), $signed(w_i1n.val) - w_fb, ACC_WIDTH);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_pdm <= 1'b0;
    end else if (clear) begin
      r_i1  <= '0;
      r_i2  <= '0;
      r_pdm <= 1'b0;
    end else if (step) begin
      r_i1  <= w_i1n.val[ACC_WIDTH-1:0];
      r_i2  <= w_i2n.val[ACC_WIDTH-1:0];
      r_pdm <= ($signed(w_i2n.val) >= 0);
    end
  end

  always_comb begin
    pdm = r_pdm;
    sat = step & ~clear & (w_i1n.sat | w_i2n.sat);
  end

endmodule

// File: rtl/dac_sigma_delta.sv
// Stereo sigma-delta DAC datapath: L/R sample capture, mute, two modulators,
// sticky saturation flags and a committed-frame counter.
module dac_sigma_delta
  import dac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DAC_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = DAC_ACC_WIDTH,
  parameter int unsigned CNT_WIDTH  = DAC_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  load_data,
  input  logic                  channel_sel,
  input  logic                  load_sigma,
  input  logic                  reset_sigma,
  input  logic                  mute,
  input  logic                  clr_status,
  output logic                  pdm_l,
  output logic                  pdm_r,
  output logic [1:0]            sat_flag,
  output logic [CNT_WIDTH-1:0]  frame_count
);

  if (ACC_WIDTH < DATA_WIDTH + 3) begin : g_bad_acc
    $error("dac_sigma_delta: ACC_WIDTH must be >= DATA_WIDTH+3");
  end

  logic [DATA_WIDTH-1:0] r_shadow_l;
  logic [DATA_WIDTH-1:0] r_active_l;
  logic [DATA_WIDTH-1:0] r_active_r;
  logic [CNT_WIDTH-1:0]  r_frame_count;
  logic [1:0]            r_sat_flag;

  dac_ch_e               w_ch;
  logic                  w_load_l;
  logic                  w_commit;
  logic [ACC_WIDTH-1:0]  w_x_l;
  logic [ACC_WIDTH-1:0]  w_x_r;
  logic                  w_pdm_l;
  logic                  w_pdm_r;
  logic                  w_sat_l;
  logic                  w_sat_r;

  always_comb begin
    w_ch     = dac_ch_e'(channel_sel);
    w_load_l = load_data && (w_ch == DAC_CH_L);
    w_commit = load_data && (w_ch == DAC_CH_R);
    w_x_l    = mute ? '0 : ACC_WIDTH'($signed(r_active_l));
    w_x_r    = mute ? '0 : ACC_WIDTH'($signed(r_active_r));
  end

  // An R strobe commits whatever sits in the L shadow, stale or not.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_shadow_l    <= '0;
      r_active_l    <= '0;
      r_active_r    <= '0;
      r_frame_count <= '0;
      r_sat_flag    <= '0;
    end else begin
      if (w_load_l) begin
        r_shadow_l <= sample_in;
      end
      if (w_commit) begin
        r_active_l    <= r_shadow_l;
        r_active_r    <= sample_in;
        r_frame_count <= r_frame_count + CNT_WIDTH'(1);
      end
      r_sat_flag <= (clr_status ? 2'b00 : r_sat_flag) | {w_sat_r, w_sat_l};
    end
  end

  dac_sd_channel #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_ch_l (
    .clk    (clk),
    .resetn (resetn),
    .x      (w_x_l),
    .step   (load_sigma),
    .clear  (reset_sigma),
    .pdm    (w_pdm_l),
    .sat    (w_sat_l)
  );

  dac_sd_channel #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_ch_r (
    .clk    (clk),
    .resetn (resetn),
    .x      (w_x_r),
    .step   (load_sigma),
    .clear  (reset_sigma),
    .pdm    (w_pdm_r),
    .sat    (w_sat_r)
  );

  always_comb begin
    pdm_l       = w_pdm_l;
    pdm_r       = w_pdm_r;
    sat_flag    = r_sat_flag;
    frame_count = r_frame_count;
  end

endmodule

// File: tb/tb_dac_sigma_delta.sv
// Directed self-checking bench for dac_sigma_delta (default widths plus a narrow-integrator copy).
module tb_dac_sigma_delta;

  logic        clk;
  logic        resetn;
  logic [15:0] sample_in;
  logic        load_data;
  logic        channel_sel;
  logic        load_sigma;
  logic        reset_sigma;
  logic        mute;
  logic        clr_status;

  logic        pdm_l, pdm_r;
  logic [1:0]  sat_flag;
  logic [15:0] frame_count;

  logic        pdm_l_s, pdm_r_s;
  logic [1:0]  sat_flag_s;
  logic [3:0]  frame_count_s;

  int unsigned n_cmp;
  int unsigned n_err;

  dac_sigma_delta #(
    .DATA_WIDTH (16),
    .ACC_WIDTH  (20),
    .CNT_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .sample_in   (sample_in),
    .load_data   (load_data),
    .channel_sel (channel_sel),
    .load_sigma  (load_sigma),
    .reset_sigma (reset_sigma),
    .mute        (mute),
    .clr_status  (clr_status),
    .pdm_l       (pdm_l),
    .pdm_r       (pdm_r),
    .sat_flag    (sat_flag),
    .frame_count (frame_count)
  );

  // Narrow integrators (DATA_WIDTH+3) and a 4-bit frame counter.
  dac_sigma_delta #(
    .DATA_WIDTH (16),
    .ACC_WIDTH  (19),
    .CNT_WIDTH  (4)
  ) dut_s (
    .clk         (clk),
    .resetn      (resetn),
    .sample_in   (sample_in),
    .load_data   (load_data),
    .channel_sel (channel_sel),
    .load_sigma  (load_sigma),
    .reset_sigma (reset_sigma),
    .mute        (mute),
    .clr_status  (clr_status),
    .pdm_l       (pdm_l_s),
    .pdm_r       (pdm_r_s),
    .sat_flag    (sat_flag_s),
    .frame_count (frame_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_pair(input logic [15:0] l, input logic [15:0] r);
    load_data   = 1'b1;
    channel_sel = 1'b0;
    sample_in   = l;
    tick();
    channel_sel = 1'b1;
    sample_in   = r;
    tick();
    load_data   = 1'b0;
    channel_sel = 1'b0;
  endtask

  task automatic clear_mod();
    reset_sigma = 1'b1;
    tick();
    reset_sigma = 1'b0;
  endtask

  task automatic run_steps(input int n, output int cl, output int cr);
    cl = 0;
    cr = 0;
    load_sigma = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      cl += int'(pdm_l);
      cr += int'(pdm_r);
    end
    load_sigma = 1'b0;
  endtask

  int cl, cr;

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    resetn      = 1'b0;
    sample_in   = '0;
    load_data   = 1'b0;
    channel_sel = 1'b0;
    load_sigma  = 1'b0;
    reset_sigma = 1'b0;
    mute        = 1'b0;
    clr_status  = 1'b0;

    repeat (3) tick();
    chk_eq("rst_pdm_l", 32'(pdm_l), 32'd0);
    chk_eq("rst_pdm_r", 32'(pdm_r), 32'd0);
    chk_eq("rst_sat", 32'(sat_flag), 32'd0);
    chk_eq("rst_fc", 32'(frame_count), 32'd0);
    resetn = 1'b1;
    tick();

    // Capture order: L alone must not reach the active register.
    load_data   = 1'b1;
    channel_sel = 1'b0;
    sample_in   = 16'h1234;
    tick();
    chk_eq("cap_l_only", 32'(dut.r_active_l), 32'h0);
    channel_sel = 1'b1;
    sample_in   = 16'hEDCC;
    tick();
    load_data   = 1'b0;
    chk_eq("cap_act_l", 32'(dut.r_active_l), 32'h1234);
    chk_eq("cap_act_r", 32'(dut.r_active_r), 32'hEDCC);
    chk_eq("cap_fc", 32'(frame_count), 32'd1);

    // DC density: L = +half scale -> 75 %, R = 0 -> 50 %.
    load_pair(16'h4000, 16'h0000);
    chk_eq("fc_two", 32'(frame_count), 32'd2);
    clear_mod();
    run_steps(4096, cl, cr);
    chk_eq("dens_half", (cl >= 3068 && cl <= 3076) ? 32'd3072 : 32'(cl), 32'd3072);
    chk_eq("dens_zero", (cr >= 2044 && cr <= 2052) ? 32'd2048 : 32'(cr), 32'd2048);
    chk_eq("dens_nosat", 32'(sat_flag), 32'd0);

    mute = 1'b1;
    clear_mod();
    run_steps(4096, cl, cr);
    mute = 1'b0;
    chk_eq("mute_dens_l", (cl >= 2044 && cl <= 2052) ? 32'd2048 : 32'(cl), 32'd2048);
    chk_eq("mute_dens_r", (cr >= 2044 && cr <= 2052) ? 32'd2048 : 32'(cr), 32'd2048);

    // reset_sigma wins over load_sigma.
    run_steps(5, cl, cr);
    reset_sigma = 1'b1;
    load_sigma  = 1'b1;
    tick();
    reset_sigma = 1'b0;
    load_sigma  = 1'b0;
    chk_eq("coll_rst_i1", 32'(dut.u_ch_l.r_i1), 32'd0);
    chk_eq("coll_rst_i2", 32'(dut.u_ch_l.r_i2), 32'd0);
    chk_eq("coll_rst_pdm_l", 32'(pdm_l), 32'd0);
    chk_eq("coll_rst_pdm_r", 32'(pdm_r), 32'd0);

    // R commit with a step: step uses old pair (+4096 / -4096), next step the new one.
    load_pair(16'h1000, 16'hF000);
    clear_mod();
    load_data   = 1'b1;
    channel_sel = 1'b0;
    sample_in   = 16'h2000;
    tick();
    channel_sel = 1'b1;
    sample_in   = 16'hE000;
    load_sigma  = 1'b1;
    tick();
    load_data   = 1'b0;
    channel_sel = 1'b0;
    chk_eq("coll_act_l", 32'(dut.r_active_l), 32'h2000);
    chk_eq("coll_i1_l", 32'(dut.u_ch_l.r_i1), 32'd36864);
    chk_eq("coll_i1_r", 32'(dut.u_ch_r.r_i1), 32'd28672);
    chk_eq("coll_pdm_l", 32'(pdm_l), 32'd1);
    chk_eq("coll_pdm_r", 32'(pdm_r), 32'd1);
    tick();
    load_sigma = 1'b0;
    chk_eq("next_i1_l", 32'(dut.u_ch_l.r_i1), 32'd12288);
    chk_eq("next_i2_l", 32'(dut.u_ch_l.r_i2), 32'd49152);
    chk_eq("next_i1_r", 32'(dut.u_ch_r.r_i1), 32'hFFFF_D000);
    chk_eq("next_i2_r", 32'(dut.u_ch_r.r_i2), 32'd16384);

    // Near-full-scale: i2 clamps on step 7 (19-bit) and step 15 (20-bit).
    load_pair(16'h7FFF, 16'h7FFF);
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    clear_mod();
    run_steps(6, cl, cr);
    chk_eq("sat19_s6", 32'(sat_flag_s), 32'd0);
    run_steps(1, cl, cr);
    chk_eq("sat19_s7", 32'(sat_flag_s), 32'd3);
    chk_eq("sat20_s7", 32'(sat_flag), 32'd0);
    run_steps(7, cl, cr);
    chk_eq("sat20_s14", 32'(sat_flag), 32'd0);
    run_steps(1, cl, cr);
    chk_eq("sat20_s15", 32'(sat_flag), 32'd3);

    clr_status = 1'b1;
    load_sigma = 1'b1;
    tick();
    load_sigma = 1'b0;
    chk_eq("clr_set_wins", 32'(sat_flag), 32'd3);
    tick();
    clr_status = 1'b0;
    chk_eq("clr_clears", 32'(sat_flag), 32'd0);
    chk_eq("clr_clears_s", 32'(sat_flag_s), 32'd0);

    // Asynchronous reset between edges while stepping.
    load_sigma = 1'b1;
    tick();
    chk_eq("pre_rst_sat", 32'(sat_flag), 32'd3);
    chk_eq("pre_rst_pdm", 32'(pdm_l), 32'd1);
    chk_eq("pre_rst_fc", 32'(frame_count), 32'd5);
    #3;
    resetn = 1'b0;
    #1;
    chk_eq("arst_pdm_l", 32'(pdm_l), 32'd0);
    chk_eq("arst_pdm_r", 32'(pdm_r), 32'd0);
    chk_eq("arst_sat", 32'(sat_flag), 32'd0);
    chk_eq("arst_fc", 32'(frame_count), 32'd0);
    #2;
    load_sigma = 1'b0;
    resetn     = 1'b1;
    tick();

    // Frame counter wrap on the 4-bit copy.
    load_data   = 1'b1;
    channel_sel = 1'b1;
    sample_in   = 16'h0001;
    repeat (15) tick();
    chk_eq("fc_max", 32'(frame_count_s), 32'hF);
    tick();
    load_data   = 1'b0;
    channel_sel = 1'b0;
    chk_eq("fc_wrap", 32'(frame_count_s), 32'h0);
    chk_eq("fc_wide", 32'(frame_count), 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
